// File: rtl/lvds_frame_sync.sv
// lvds_frame_sync: frame-alignment controller for the 7-bit LVDS word path.
// Latency: data_out/data_vld/sof/locked/err_cnt/bitslip are registered, 1 cycle after the qualifying word.
// Backpressure: none; one word per clock in, downstream must accept every data_vld beat.
//
// Ports:
//   clk       word clock, all state on posedge
//   rst_n     asynchronous active-low reset
//   word_in   deserialized word: [6] frame marker, [5:0] payload
//   word_vld  word_in valid this cycle
//   bitslip   one-cycle request to slip the deserializer by one bit
//   locked    frame alignment established
//   data_out  payload of the forwarded word
//   data_vld  data_out valid (locked, payload positions only)
//   sof       first payload word of a frame, qualified by data_vld
//   err_cnt   saturating count of lock-loss events
module lvds_frame_sync #(
  parameter int FRAME_LEN  = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int SLIP_WAIT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] word_in,
  input  logic       word_vld,
  output logic       bitslip,
  output logic       locked,
  output logic [5:0] data_out,
  output logic       data_vld,
  output logic       sof,
  output logic [7:0] err_cnt
);

  localparam int PW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] POS_ONE   = PW'(1);
  localparam logic [7:0]    HUNT_LAST = 8'(2 * FRAME_LEN - 1);
  localparam logic [7:0]    SLIP_LAST = 8'(SLIP_WAIT - 1);
  localparam logic [3:0]    LOCK_N    = 4'(LOCK_CNT);
  localparam logic [3:0]    UNLOCK_N  = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {HUNT, SLIPW, VERIFY, LOCK} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pos, pos_nxt;          // position of the next valid word
  logic [7:0]    hunt_cnt, hunt_nxt;
  logic [7:0]    slip_cnt, slip_nxt;
  logic [3:0]    good_cnt, good_nxt;
  logic [3:0]    bad_cnt, bad_nxt;
  logic          frame_bad, frame_bad_nxt; // stray marker seen in current LOCK frame

  logic          bitslip_nxt, locked_nxt, data_vld_nxt, sof_nxt;
  logic [5:0]    data_out_nxt;
  logic [7:0]    err_nxt;

  logic          mk, at_pos0, word_ok;
  logic [PW-1:0] pos_inc;
  logic [3:0]    good_inc, bad_inc;

  assign mk       = word_in[6];
  assign at_pos0  = (pos == '0);
  assign word_ok  = at_pos0 ? mk : !mk;
  assign pos_inc  = (pos == POS_LAST) ? '0 : pos + POS_ONE;
  assign good_inc = good_cnt + 4'd1;
  assign bad_inc  = bad_cnt + 4'd1;

  always_comb begin
    state_nxt     = state;
    pos_nxt       = pos;
    hunt_nxt      = hunt_cnt;
    slip_nxt      = slip_cnt;
    good_nxt      = good_cnt;
    bad_nxt       = bad_cnt;
    frame_bad_nxt = frame_bad;
    bitslip_nxt   = 1'b0;
    data_vld_nxt  = 1'b0;
    sof_nxt       = 1'b0;
    data_out_nxt  = data_out;
    err_nxt       = err_cnt;

    case (state)
      HUNT: begin
        if (word_vld) begin
          if (mk) begin
            // The marker word itself is position 0, so the next word is position 1.
            state_nxt = VERIFY;
            pos_nxt   = POS_ONE;
            good_nxt  = '0;
          end else if (hunt_cnt == HUNT_LAST) begin
            bitslip_nxt = 1'b1;
            state_nxt   = SLIPW;
            slip_nxt    = '0;
          end else begin
            hunt_nxt = hunt_cnt + 8'd1;
          end
        end
      end

      SLIPW: begin
        // Counts clock cycles, not words: the deserializer needs settling time.
        if (slip_cnt == SLIP_LAST) begin
          state_nxt = HUNT;
          hunt_nxt  = '0;
        end else begin
          slip_nxt = slip_cnt + 8'd1;
        end
      end

      VERIFY: begin
        if (word_vld) begin
          pos_nxt = pos_inc;
          if (!word_ok) begin
            bitslip_nxt = 1'b1;
            state_nxt   = SLIPW;
            slip_nxt    = '0;
            good_nxt    = '0;
          end else if (at_pos0) begin
            good_nxt = good_inc;
            if (good_inc == LOCK_N) begin
              state_nxt     = LOCK;
              bad_nxt       = '0;
              frame_bad_nxt = 1'b0;
            end
          end
        end
      end

      LOCK: begin
        // Flywheel: pos is never realigned here, errors only accumulate.
        if (word_vld) begin
          pos_nxt = pos_inc;
          if (at_pos0) begin
            frame_bad_nxt = 1'b0;
            if (frame_bad || !mk) begin
              if (bad_inc == UNLOCK_N) begin
                state_nxt = HUNT;
                hunt_nxt  = '0;
                if (err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
              end else begin
                bad_nxt = bad_inc;
              end
            end else begin
              bad_nxt = '0;
            end
          end else begin
            data_vld_nxt = 1'b1;
            data_out_nxt = word_in[5:0];
            sof_nxt      = (pos == POS_ONE);
            if (mk) frame_bad_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = HUNT;
    endcase

    locked_nxt = (state_nxt == LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      pos       <= '0;
      hunt_cnt  <= '0;
      slip_cnt  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      frame_bad <= 1'b0;
      bitslip   <= 1'b0;
      locked    <= 1'b0;
      data_out  <= '0;
      data_vld  <= 1'b0;
      sof       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      hunt_cnt  <= hunt_nxt;
      slip_cnt  <= slip_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      frame_bad <= frame_bad_nxt;
      bitslip   <= bitslip_nxt;
      locked    <= locked_nxt;
      data_out  <= data_out_nxt;
      data_vld  <= data_vld_nxt;
      sof       <= sof_nxt;
      err_cnt   <= err_nxt;
    end
  end

endmodule
